udma_wrr_arbiter: RTL and testbench

Weighted round-robin arbiter for uDMA channels with two priority classes and a selectable pointer policy. It arbitrates among N channel requests in the same cycle, giving each channel up to its programmed weight of consecutive acknowledged grants. Pointer and credit state advance only when the uDMA controller acknowledges a grant. It sits between the channel request vector and the uDMA transfer controller and is the parametrised successor of the single-class round-robin arbiter.

---
 rtl/udma_wrr_arbiter.sv | 115 +++++++++++
 tb/tb_udma_wrr_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/udma_wrr_arbiter.sv
// Weighted round-robin arbiter for uDMA channels: two priority classes,
// per-class one-hot pointer and credit counter, state advanced only on acknowledged grants.
module udma_wrr_arbiter #(
    parameter int N  = 8,
    parameter int WW = 4,
    parameter int IW = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    hiprio_i,
    input  logic [N*WW-1:0] weight_i,
    input  logic            mode_i,
    input  logic            grant_ack_i,
    output logic [N-1:0]    grant_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            anyGrant_o
);

    logic [N-1:0]  ptr_hi_q, ptr_hi_d, ptr_lo_q, ptr_lo_d;
    logic [WW-1:0] cnt_hi_q, cnt_hi_d, cnt_lo_q, cnt_lo_d;

    logic          use_hi;
    logic [N-1:0]  elig;
    logic [N-1:0]  ptr_sel;
    logic [WW-1:0] cnt_sel;
    logic [IW-1:0] p_idx;
    logic [IW-1:0] g_idx;
    logic [N-1:0]  gnt;
    logic          found;
    logic [WW-1:0] w_g;
    logic [WW-1:0] w_eff;
    logic [WW:0]   cnt_new;
    logic [N-1:0]  ptr_new;
    logic [WW-1:0] cnt_upd;
    int            pos;

    // Class selection and cyclic scan starting at (and including) the class pointer
    always_comb begin
        use_hi  = |(req_i & hiprio_i);
        elig    = use_hi ? (req_i & hiprio_i) : req_i;
        ptr_sel = use_hi ? ptr_hi_q : ptr_lo_q;
        cnt_sel = use_hi ? cnt_hi_q : cnt_lo_q;

        p_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr_sel[i]) p_idx = IW'(i);
        end

        found = 1'b0;
        g_idx = '0;
        gnt   = '0;
        pos   = 0;
        for (int off = 0; off < N; off++) begin
            pos = int'(p_idx) + off;
            if (pos >= N) pos = pos - N;
            if (!found && elig[pos]) begin
                found    = 1'b1;
                g_idx    = IW'(pos);
                gnt[pos] = 1'b1;
            end
        end
    end

    assign grant_o    = gnt;
    assign gnt_idx_o  = g_idx;
    assign anyGrant_o = |req_i;

    // Credit accounting for the granted channel; a zero weight behaves as one
    always_comb begin
        w_g     = weight_i[g_idx*WW +: WW];
        w_eff   = (w_g == '0) ? WW'(1) : w_g;
        cnt_new = (g_idx == p_idx) ? ({1'b0, cnt_sel} + 1'b1) : (WW+1)'(1);

        if (mode_i) begin
            ptr_new = {ptr_sel[N-2:0], ptr_sel[N-1]};
            cnt_upd = '0;
        end else if (cnt_new >= {1'b0, w_eff}) begin
            ptr_new = {gnt[N-2:0], gnt[N-1]};
            cnt_upd = '0;
        end else begin
            ptr_new = gnt;
            cnt_upd = cnt_new[WW-1:0];
        end

        ptr_hi_d = ptr_hi_q;
        cnt_hi_d = cnt_hi_q;
        ptr_lo_d = ptr_lo_q;
        cnt_lo_d = cnt_lo_q;
        if (grant_ack_i && anyGrant_o) begin
            if (use_hi) begin
                ptr_hi_d = ptr_new;
                cnt_hi_d = cnt_upd;
            end else begin
                ptr_lo_d = ptr_new;
                cnt_lo_d = cnt_upd;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_hi_q <= N'(1);
            ptr_lo_q <= N'(1);
            cnt_hi_q <= '0;
            cnt_lo_q <= '0;
        end else begin
            ptr_hi_q <= ptr_hi_d;
            ptr_lo_q <= ptr_lo_d;
            cnt_hi_q <= cnt_hi_d;
            cnt_lo_q <= cnt_lo_d;
        end
    end

endmodule

// File: tb/tb_udma_wrr_arbiter.sv
// Bench for udma_wrr_arbiter (N=4): table of hand-derived vectors plus
// hand-written burst sequences, checked through an expected-result queue.
module tb_udma_wrr_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int IW = 2;

    logic            clk_i = 1'b0;
    logic            rstn_i = 1'b0;
    logic [N-1:0]    req_i = '0;
    logic [N-1:0]    hiprio_i = '0;
    logic [N*WW-1:0] weight_i = '0;
    logic            mode_i = 1'b0;
    logic            grant_ack_i = 1'b0;
    logic [N-1:0]    grant_o;
    logic [IW-1:0]   gnt_idx_o;
    logic            anyGrant_o;

    udma_wrr_arbiter #(.N(N), .WW(WW), .IW(IW)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_i       (req_i),
        .hiprio_i    (hiprio_i),
        .weight_i    (weight_i),
        .mode_i      (mode_i),
        .grant_ack_i (grant_ack_i),
        .grant_o     (grant_o),
        .gnt_idx_o   (gnt_idx_o),
        .anyGrant_o  (anyGrant_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic [N-1:0]  hip;
        logic [15:0]   w;
        logic          mode;
        logic          ack;
        logic          any;
        logic [IW-1:0] idx;
    } vec_t;

    typedef struct {
        int            id;
        logic          any;
        logic [IW-1:0] idx;
        logic [N-1:0]  gnt;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic rst, input logic [N-1:0] req, input logic [N-1:0] hip,
                                input logic [15:0] w, input logic mode, input logic ack,
                                input logic any, input logic [IW-1:0] idx);
        vec_t v;
        v.rst = rst; v.req = req; v.hip = hip; v.w = w;
        v.mode = mode; v.ack = ack; v.any = any; v.idx = idx;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        logic [N-1:0] one;
        @(negedge clk_i);
        rstn_i      = !v.rst;
        req_i       = v.req;
        hiprio_i    = v.hip;
        weight_i    = v.w;
        mode_i      = v.mode;
        grant_ack_i = v.ack;
        one   = 4'b0001;
        e.id  = id;
        e.any = v.any;
        e.idx = v.idx;
        e.gnt = v.any ? (one << v.idx) : 4'b0000;
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (anyGrant_o !== e.any) begin
            n_fail++;
            $display("FAIL any vec%0d: got %b expected %b", e.id, anyGrant_o, e.any);
        end
        n_checks++;
        if (gnt_idx_o !== e.idx) begin
            n_fail++;
            $display("FAIL idx vec%0d: got %0d expected %0d", e.id, gnt_idx_o, e.idx);
        end
        n_checks++;
        if (grant_o !== e.gnt) begin
            n_fail++;
            $display("FAIL grant vec%0d: got %b expected %b", e.id, grant_o, e.gnt);
        end
    endtask

    initial begin
        // Equal weights, plain rotation with wrap
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 16'h1111, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 16'h1111, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1111, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1111, 0, 1, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1111, 0, 1, 1, 2));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1111, 0, 1, 1, 3));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1111, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1111, 0, 1, 1, 1));
        // w0=3
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 2));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 3));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 1));
        // High class preempts; low-class state frozen meanwhile
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 16'h1113, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0100, 16'h1113, 0, 1, 1, 2));
        tbl.push_back(mk(0, 4'b1111, 4'b0100, 16'h1113, 0, 1, 1, 2));
        tbl.push_back(mk(0, 4'b1111, 4'b0100, 16'h1113, 0, 1, 1, 2));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 16'h1113, 0, 1, 1, 1));
        // Blind round robin
        tbl.push_back(mk(1, 4'b1010, 4'b0000, 16'h0000, 1, 0, 1, 1));
        tbl.push_back(mk(0, 4'b1010, 4'b0000, 16'h0000, 1, 1, 1, 1));
        tbl.push_back(mk(0, 4'b1010, 4'b0000, 16'h0000, 1, 1, 1, 1));
        tbl.push_back(mk(0, 4'b1010, 4'b0000, 16'h0000, 1, 1, 1, 3));
        tbl.push_back(mk(0, 4'b1010, 4'b0000, 16'h0000, 1, 1, 1, 3));
        tbl.push_back(mk(0, 4'b1010, 4'b0000, 16'h0000, 1, 1, 1, 1));
        // No ack holds state; ack with no request is ignored
        tbl.push_back(mk(1, 4'b0110, 4'b0000, 16'h1111, 0, 0, 1, 1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 4'b0110, 4'b0000, 16'h1111, 0, 0, 1, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 16'h1111, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0110, 4'b0000, 16'h1111, 0, 1, 1, 1));
        tbl.push_back(mk(0, 4'b0110, 4'b0000, 16'h1111, 0, 0, 1, 2));
        // Zero weights act as one
        tbl.push_back(mk(1, 4'b0011, 4'b0000, 16'h0000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 16'h0000, 0, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 16'h0000, 0, 1, 1, 1));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 16'h0000, 0, 1, 1, 0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Favoured channel drops mid-burst: w0=3, w1=2
        apply(mk(1, 4'b1111, 4'b0000, 16'h1123, 0, 0, 1, 0), 100);
        apply(mk(0, 4'b1111, 4'b0000, 16'h1123, 0, 1, 1, 0), 101);
        apply(mk(0, 4'b1110, 4'b0000, 16'h1123, 0, 1, 1, 1), 102);
        apply(mk(0, 4'b1111, 4'b0000, 16'h1123, 0, 1, 1, 1), 103);
        apply(mk(0, 4'b1111, 4'b0000, 16'h1123, 0, 0, 1, 2), 104);

        // Reset in the middle of a burst restarts the count
        apply(mk(1, 4'b0001, 4'b0000, 16'h1113, 0, 0, 1, 0), 200);
        apply(mk(0, 4'b0001, 4'b0000, 16'h1113, 0, 1, 1, 0), 201);
        apply(mk(0, 4'b0001, 4'b0000, 16'h1113, 0, 1, 1, 0), 202);
        apply(mk(1, 4'b0001, 4'b0000, 16'h1113, 0, 1, 1, 0), 203);
        apply(mk(0, 4'b0011, 4'b0000, 16'h1113, 0, 1, 1, 0), 204);
        apply(mk(0, 4'b0011, 4'b0000, 16'h1113, 0, 1, 1, 0), 205);
        apply(mk(0, 4'b0011, 4'b0000, 16'h1113, 0, 1, 1, 0), 206);
        apply(mk(0, 4'b0011, 4'b0000, 16'h1113, 0, 0, 1, 1), 207);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
